hazard_sequencer: RTL

//  ID-stage pipeline controller for the 5-stage RV32 core. Decodes the IF/ID instruction and sequences the front end.

---
 rtl/hazard_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: ID-stage front-end controller handling load-use, taken-branch and memory-busy sequencing.
module hazard_sequencer #(
  parameter int LU_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      instr_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             branch_eq_i,
  input  logic             mem_stall_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             branch_taken_o,
  output logic             noop_o,
  output logic             freeze_o,
  output logic [1:0]       imm_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, LU_STALL, MEM_STALL} state_t;
  state_t state, state_nx;
  logic [3:0] lu_cnt, lu_cnt_nx;
  logic [6:0] opc;
  logic [4:0] rs1, rs2;
  logic [2:0] f3;
  logic uses_rs1, uses_rs2, lu_haz, br_tk, stall_inc;
  assign opc = instr_i[6:0];
  assign rs1 = instr_i[19:15];
  assign rs2 = instr_i[24:20];
  assign f3 = instr_i[14:12];
  assign uses_rs1 = opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
  assign uses_rs2 = opc inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign imm_sel_o = opc == 7'b0100011 ? 2'b01 : opc == 7'b1100011 ? 2'b10 : 2'b00;
  assign lu_haz = idex_memread_i && idex_rd_i != 5'd0 &&
                  ((uses_rs1 && rs1 == idex_rd_i) || (uses_rs2 && rs2 == idex_rd_i));
  assign br_tk = opc == 7'b1100011 && ((f3 == 3'b000 && branch_eq_i) || (f3 == 3'b001 && !branch_eq_i));
  always_comb begin
    state_nx = state;
    lu_cnt_nx = lu_cnt;
    pc_write_o = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    branch_taken_o = 1'b0;
    noop_o = 1'b0;
    freeze_o = 1'b0;
    case (state)
      IDLE: begin
        noop_o = 1'b1;
        state_nx = start_i ? RUN : IDLE;
      end
      RUN: begin
        if (mem_stall_i) begin
          freeze_o = 1'b1;
          state_nx = MEM_STALL;
        end else if (lu_haz) begin
          noop_o = 1'b1;
          lu_cnt_nx = 4'(LU_CYCLES - 1);
          state_nx = LU_CYCLES == 1 ? RUN : LU_STALL;
        end else begin
          pc_write_o = 1'b1;
          ifid_write_o = 1'b1;
          ifid_flush_o = br_tk;
          branch_taken_o = br_tk;
        end
      end
      LU_STALL: begin
        if (mem_stall_i) begin
          freeze_o = 1'b1;
          state_nx = MEM_STALL;
        end else begin
          noop_o = 1'b1;
          lu_cnt_nx = lu_cnt - 4'd1;
          state_nx = lu_cnt <= 4'd1 ? RUN : LU_STALL;
        end
      end
      default: begin
        // lu_cnt was held on entry, so a nonzero value means bubbles are still owed
        freeze_o = 1'b1;
        state_nx = mem_stall_i ? MEM_STALL : lu_cnt != 4'd0 ? LU_STALL : RUN;
      end
    endcase
  end
  assign stall_inc = state != IDLE && (freeze_o || (noop_o && !pc_write_o));
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      lu_cnt <= 4'd0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state <= state_nx;
      lu_cnt <= lu_cnt_nx;
      if (stall_inc && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (ifid_flush_o && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
endmodule
